// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD definitions for the multi-digit decimal counter.
//                Provides the 4-bit digit type, the legal digit limits and a
//                clamp helper that forces non-decimal codes (A..F) to 9.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-decimal nibbles (10..15) are pulled back to the largest legal digit
    // so the counter can never hold an invalid BCD code.
    function automatic bcd_digit_t bcd_clamp(input logic [3:0] value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit register with its next-value logic.
//                The digit steps once when step_in is high, in the direction
//                given by up_dn, rolling 9->0 going up and 0->9 going down.
//                step_out flags that this digit is at its roll-over value
//                while a step is arriving, i.e. the carry/borrow propagates.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                step_in     - carry (up) or borrow (down) from lower digit
//                up_dn       - 1 = increment, 0 = decrement
//                load        - parallel load strobe (overrides stepping)
//                freeze      - suppress stepping (counter saturated)
//                ld_val      - load value, clamped to 9
//                digit       - registered digit value
//                step_out    - carry/borrow towards the next digit
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_in,
    input  logic       up_dn,
    input  logic       load,
    input  logic       freeze,
    input  bcd_digit_t ld_val,
    output bcd_digit_t digit,
    output logic       step_out
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_nxt;
    logic       at_limit;

    // Roll-over value depends on direction: 9 counting up, 0 counting down.
    assign at_limit = up_dn ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
    assign step_out = step_in & at_limit;

    always_comb begin
        digit_nxt = digit_q;
        if (load) begin
            digit_nxt = bcd_clamp(ld_val);
        end else if (step_in && !freeze) begin
            if (up_dn) begin
                digit_nxt = at_limit ? BCD_MIN : (digit_q + 4'd1);
            end else begin
                digit_nxt = at_limit ? BCD_MAX : (digit_q - 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_nxt;
        end
    end

    assign digit = digit_q;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_multidigit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_multidigit_counter
//  Description : Synchronous NUM_DIGITS-digit BCD up/down counter with
//                parallel load, count enable, wrap or saturate behaviour at
//                the range limits, a one-cycle terminal-count pulse and a
//                sticky overflow/underflow flag. All outputs are registered.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                en          - count enable, one step per cycle
//                up_dn       - 1 = count up, 0 = count down
//                load        - parallel load strobe (priority over en)
//                load_val    - BCD load value, digit i at [4i+3:4i]
//                cnt_o       - current count, digit 0 least significant
//                tc_o        - one-cycle pulse when the count wraps
//                ovf_o       - sticky flag: a step past a limit was attempted
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_multidigit_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int WRAP       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] cnt_o,
    output logic                    tc_o,
    output logic                    ovf_o
);

    localparam bit SATURATE = (WRAP == 0);

    // step[i] is the carry/borrow arriving at digit i; step[0] is the enable
    // itself, step[NUM_DIGITS] means every digit sits at its roll-over value,
    // i.e. this step crosses the counter range limit.
    logic [NUM_DIGITS:0] step;
    logic                limit_step;
    logic                freeze;
    logic                tc_q;
    logic                ovf_q;

    assign step[0]    = en;
    assign limit_step = step[NUM_DIGITS];

    // In saturate mode the whole counter holds when a step would cross the
    // limit; the digits themselves only see a freeze, the chain stays intact.
    assign freeze = SATURATE & limit_step;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst      (rst),
                .step_in  (step[i]),
                .up_dn    (up_dn),
                .load     (load),
                .freeze   (freeze),
                .ld_val   (load_val[4*i +: 4]),
                .digit    (cnt_o[4*i +: 4]),
                .step_out (step[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (load) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            // limit_step is only ever high while en is high, so an idle cycle
            // naturally drops the pulse back to zero.
            tc_q <= limit_step & ~SATURATE;
            if (limit_step) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign tc_o  = tc_q;
    assign ovf_o = ovf_q;

endmodule : bcd_multidigit_counter
`default_nettype wire

// File: tb/tb_bcd_multidigit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_multidigit_counter
//  Description : Self-checking bench for bcd_multidigit_counter. Three
//                instances (2 digits wrap, 2 digits saturate, 4 digits wrap)
//                share the same stimulus and are compared every cycle against
//                an integer-valued reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_multidigit_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;

    logic [7:0]  cnt_2w;
    logic        tc_2w;
    logic        ovf_2w;
    logic [7:0]  cnt_2s;
    logic        tc_2s;
    logic        ovf_2s;
    logic [15:0] cnt_4w;
    logic        tc_4w;
    logic        ovf_4w;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: count held as a plain integer.
    int  m_val [3];
    bit  m_tc  [3];
    bit  m_ovf [3];
    int  m_nd  [3] = '{2, 2, 4};
    bit  m_wr  [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    bcd_multidigit_counter #(.NUM_DIGITS(2), .WRAP(1)) u_d2w (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[7:0]), .cnt_o(cnt_2w), .tc_o(tc_2w), .ovf_o(ovf_2w)
    );

    bcd_multidigit_counter #(.NUM_DIGITS(2), .WRAP(0)) u_d2s (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[7:0]), .cnt_o(cnt_2s), .tc_o(tc_2s), .ovf_o(ovf_2s)
    );

    bcd_multidigit_counter #(.NUM_DIGITS(4), .WRAP(1)) u_d4w (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cnt_o(cnt_4w), .tc_o(tc_4w), .ovf_o(ovf_4w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int value, input int nd);
        logic [31:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            if (i < nd) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    // Advance one instance's model by one clock edge using the sampled inputs.
    task automatic model_step(input int k);
        int top;
        int d;
        top = 1;
        for (int i = 0; i < m_nd[k]; i++) top = top * 10;
        top = top - 1;
        if (rst) begin
            m_val[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
        end else if (load) begin
            m_val[k] = 0;
            for (int i = m_nd[k] - 1; i >= 0; i--) begin
                d = int'(load_val[4*i +: 4]);
                if (d > 9) d = 9;
                m_val[k] = m_val[k] * 10 + d;
            end
            m_tc[k] = 0; m_ovf[k] = 0;
        end else if (en) begin
            m_tc[k] = 0;
            if (up_dn) begin
                if (m_val[k] == top) begin
                    m_ovf[k] = 1;
                    if (m_wr[k]) begin m_val[k] = 0; m_tc[k] = 1; end
                end else begin
                    m_val[k] = m_val[k] + 1;
                end
            end else begin
                if (m_val[k] == 0) begin
                    m_ovf[k] = 1;
                    if (m_wr[k]) begin m_val[k] = top; m_tc[k] = 1; end
                end else begin
                    m_val[k] = m_val[k] - 1;
                end
            end
        end else begin
            m_tc[k] = 0;
        end
    endtask

    task automatic tick();
        logic [31:0] o_cnt [3];
        logic        o_tc  [3];
        logic        o_ovf [3];
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        o_cnt[0] = {24'b0, cnt_2w}; o_tc[0] = tc_2w; o_ovf[0] = ovf_2w;
        o_cnt[1] = {24'b0, cnt_2s}; o_tc[1] = tc_2s; o_ovf[1] = ovf_2s;
        o_cnt[2] = {16'b0, cnt_4w}; o_tc[2] = tc_4w; o_ovf[2] = ovf_4w;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cnt[%0d]", k), o_cnt[k], to_bcd(m_val[k], m_nd[k]));
            check($sformatf("tc[%0d]", k),  {31'b0, o_tc[k]},  {31'b0, m_tc[k]});
            check($sformatf("ovf[%0d]", k), {31'b0, o_ovf[k]}, {31'b0, m_ovf[k]});
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        tick();
        tick();
        rst = 1'b0;

        // Full up-count through the 2-digit wrap (and saturation).
        en = 1'b1; up_dn = 1'b1;
        repeat (105) tick();

        // Borrow across two digits on the 4-digit instance.
        do_load(16'h0100);
        en = 1'b1; up_dn = 1'b0;
        repeat (3) tick();

        // Saturate at 99, then step back down.
        do_load(16'h0099);
        en = 1'b1; up_dn = 1'b1;
        repeat (3) tick();
        up_dn = 1'b0;
        tick();

        // Invalid digits clamp to 9; a load beats a simultaneous enable.
        do_load(16'h00AF);
        load = 1'b1; load_val = 16'h0042; en = 1'b1;
        tick();
        load = 1'b0;

        // Reset wins over load and enable mid-count.
        do_load(16'h0057);
        en = 1'b1; up_dn = 1'b1;
        repeat (2) tick();
        rst = 1'b1; load = 1'b1; load_val = 16'h1234;
        tick();
        rst = 1'b0; load = 1'b0;
        tick();

        // Direction reversal every cycle, then idle.
        do_load(16'h0050);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = ((i % 2) == 0);
            tick();
        end
        en = 1'b0;
        repeat (5) tick();

        // 4-digit wrap in both directions.
        do_load(16'h9998);
        en = 1'b1; up_dn = 1'b1;
        repeat (3) tick();
        do_load(16'h0001);
        en = 1'b1; up_dn = 1'b0;
        repeat (3) tick();

        // Randomised traffic with loads biased toward the range limits.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            load  = ($urandom_range(0, 24) == 0);
            en    = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
            case ($urandom_range(0, 4))
                0:       load_val = 16'h9999;
                1:       load_val = 16'h0000;
                2:       load_val = 16'h0099;
                3:       load_val = 16'h9900;
                default: load_val = 16'($urandom);
            endcase
            tick();
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bcd_multidigit_counter
`default_nettype wire
